// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: sequencer that feeds a 1-bit serial sequence detector.
// It accepts a parallel word over a valid/ready handshake and shifts it into
// the detector MSB first. It counts the detector's find pulses that belong to
// that word and returns the count over a valid/ready result port.
// Optional feature macro: SEQ_CTRL_CLR_EN. When it is defined, the detector
// gets a one-cycle clear pulse before each word, so no match spans two words.

module seq_det_ctrl #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          det_in,
  output logic          det_clr,
  input  logic          det_find,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [CW-1:0] res_count,
  output logic          res_hit
);

  localparam int BW = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [W-1:0]    r_shreg;
  logic [W-1:0]    w_shreg_next;
  logic [BW-1:0]   r_bitcnt;
  logic [BW-1:0]   w_bitcnt_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            r_pend;
  logic            w_inc;
  logic            w_res_load;
  logic            r_in_ready;
  logic            r_det_in;
  logic            r_res_valid;
  logic [CW-1:0]   r_res_count;
  logic            r_res_hit;

  // A find pulse belongs to the current word only when the previous cycle presented one of its bits
  assign w_inc = r_pend & det_find;

  // Next-state, shift register, bit counter and find counter
  always_comb begin
    w_next_state  = r_state;
    w_shreg_next  = r_shreg;
    w_bitcnt_next = r_bitcnt;
    w_cnt_next    = r_cnt + CW'(w_inc);
    w_res_load    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_shreg_next  = in_data;
          w_bitcnt_next = '0;
          w_cnt_next    = '0;
`ifdef SEQ_CTRL_CLR_EN
          w_next_state  = S_CLEAR;
`else
          w_next_state  = S_SHIFT;
`endif
        end
      end
      S_CLEAR: begin
        w_next_state = S_SHIFT;
      end
      S_SHIFT: begin
        w_shreg_next  = {r_shreg[W-2:0], 1'b0};
        w_bitcnt_next = r_bitcnt + 1'b1;
        if (r_bitcnt == BW'(W - 1)) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_res_load   = 1'b1;
        w_next_state = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset drops any word in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_cnt       <= '0;
      r_pend      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_det_in    <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_count <= '0;
      r_res_hit   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_shreg     <= w_shreg_next;
      r_bitcnt    <= w_bitcnt_next;
      r_cnt       <= w_cnt_next;
      r_pend      <= (r_state == S_SHIFT);
      r_in_ready  <= (w_next_state == S_IDLE);
      r_det_in    <= (w_next_state == S_SHIFT) ? w_shreg_next[W-1] : 1'b0;
      r_res_valid <= (w_next_state == S_DONE);
      if (w_res_load) begin
        r_res_count <= w_cnt_next;
        r_res_hit   <= (w_cnt_next != '0);
      end
    end
  end

`ifdef SEQ_CTRL_CLR_EN
  logic r_det_clr;

  // Clear pulse is high for exactly the one CLEAR cycle after a word is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_det_clr <= 1'b0;
    end else begin
      r_det_clr <= (w_next_state == S_CLEAR);
    end
  end

  assign det_clr = r_det_clr;
`else
  assign det_clr = 1'b0;
`endif

  assign in_ready  = r_in_ready;
  assign det_in    = r_det_in;
  assign res_valid = r_res_valid;
  assign res_count = r_res_count;
  assign res_hit   = r_res_hit;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: self-checking bench for seq_det_ctrl using a stub detector
// (find follows det_in one cycle later, cleared by det_clr), so each word's
// expected count is its popcount. Honours SEQ_CTRL_CLR_EN for the clear cycle.

module tb_seq_det_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
`ifdef SEQ_CTRL_CLR_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif

  logic          clk;
  logic          rst;
  logic          inValid;
  logic          inReady;
  logic [W-1:0]  inData;
  logic          detIn;
  logic          detClr;
  logic          detFind = 1'b0;
  logic          resValid;
  logic          resReady;
  logic [CW-1:0] resCount;
  logic          resHit;

  int testsRun    = 0;
  int testsFailed = 0;
  int rrMode      = 0;

  // Reference timeline: busy flag, cycle index since accept, word in flight
  bit            mBusy = 1'b0;
  int            mT    = 0;
  logic [W-1:0]  mData = '0;

  seq_det_ctrl #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .det_in    (detIn),
    .det_clr   (detClr),
    .det_find  (detFind),
    .res_valid (resValid),
    .res_ready (resReady),
    .res_count (resCount),
    .res_hit   (resHit)
  );

  // Clock with first rising edge at 8 ns so the 50 ns reset release avoids both edges
  initial begin
    clk = 1'b0;
    #3;
    forever #5 clk = ~clk;
  end

  // Stub detector: find reports the previously sampled serial bit
  always @(posedge clk) begin
    if (detClr) detFind <= 1'b0;
    else        detFind <= detIn;
  end

  // Result consumer: always ready, random, or stalled, changed just after each edge
  always @(posedge clk) begin
    #1;
    case (rrMode)
      0:       resReady = 1'b1;
      1:       resReady = ($urandom_range(0, 2) != 0);
      default: resReady = 1'b0;
    endcase
  end

  // Behavioural model: one word occupies OFF clear cycles, W bit cycles, one drain cycle, then waits for the consumer
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mBusy <= 1'b0;
      mT    <= 0;
    end else if (!mBusy) begin
      if (inValid) begin
        mBusy <= 1'b1;
        mT    <= 0;
        mData <= inData;
      end
    end else if (mT >= OFF + W + 1) begin
      if (resReady) mBusy <= 1'b0;
    end else begin
      mT <= mT + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    logic expDetIn;
    logic expValid;
    expDetIn = 1'b0;
    if (mBusy && mT >= OFF && mT < OFF + W) expDetIn = mData[W - 1 - (mT - OFF)];
    expValid = mBusy && (mT >= OFF + W + 1);
    checkOutput("in_ready", inReady, !mBusy);
    checkOutput("det_in", detIn, expDetIn);
    checkOutput("det_clr", detClr, mBusy && (mT < OFF));
    checkOutput("res_valid", resValid, expValid);
    if (!rst) begin
      checkOutput("reset_count", resCount, 0);
      checkOutput("reset_hit", resHit, 0);
    end else if (expValid) begin
      checkOutput("res_count", resCount, $countones(mData));
      checkOutput("res_hit", resHit, mData != 0);
    end
  end

  // Present a word and hold it until the controller accepts it
  task automatic applyStimulus(input logic [W-1:0] d);
    bit ok;
    ok = 1'b0;
    inValid = 1'b1;
    inData  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (inReady) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  // Wait for the result handshake and pin the count to a hand-computed value
  task automatic waitResult(input string name, input int exp);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resValid && resReady) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      checkOutput(name, resCount, exp);
      checkOutput({name, "_hit"}, resHit, exp != 0);
    end else begin
      checkOutput({name, "_timeout"}, 0, 1);
    end
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios followed by randomized words with random backpressure
  initial begin
    logic [W-1:0] serial;
    logic [W-1:0] rw;
    bit           ok;
    rst      = 1'b0;
    inValid  = 1'b0;
    inData   = '0;
    resReady = 1'b1;
    #50;
    rst = 1'b1;

    applyStimulus(8'hA5);
    repeat (OFF) @(negedge clk);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      serial = {serial[W-2:0], detIn};
    end
    checkOutput("A5_serial", serial, 8'hA5);
    waitResult("A5", 4);

    applyStimulus(8'h00);
    waitResult("00", 0);
    applyStimulus(8'hFF);
    waitResult("FF", 8);

    rrMode = 2;
    applyStimulus(8'h3C);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (resValid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("3C_timeout", 0, 1);
    inValid = 1'b1;
    inData  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("3C_hold_count", resCount, 4);
      checkOutput("3C_hold_valid", resValid, 1);
      checkOutput("3C_hold_ready", inReady, 0);
    end
    rrMode = 0;
    applyStimulus(8'h5A);
    waitResult("5A", 4);

    applyStimulus(8'hFF);
    repeat (OFF + 3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_ready", inReady, 1);
    checkOutput("rst_valid", resValid, 0);
    checkOutput("rst_det_in", detIn, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    applyStimulus(8'h0F);
    waitResult("0F", 4);

    applyStimulus(8'h01);
    waitResult("01", 1);
    applyStimulus(8'h00);
`ifdef SEQ_CTRL_CLR_EN
    @(negedge clk);
    checkOutput("clr_pulse", detClr, 1);
    @(negedge clk);
    checkOutput("clr_single", detClr, 0);
`endif
    waitResult("00_after_01", 0);

    rrMode = 1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      rw = W'($urandom);
      applyStimulus(rw);
      waitResult("random", $countones(rw));
    end
    rrMode = 0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
